regfile_scoreboard: RTL and testbench

Per-thread register file for the SIMT core, parametrised in register count and data width. It adds a pending-load scoreboard, a decoupled LSU writeback port and a registered hazard flag. Loads no longer block the thread in UPDATE: the destination is marked pending, the LSU returns data later, and REQUEST flags any operand that is still pending. One instance per thread inside the core, fed by the decoder, ALU and LSU.

---
 rtl/gpu_pkg.sv | 23 ++
 rtl/reg_scoreboard.sv | 64 ++++++
 rtl/regfile_scoreboard.sv | 148 ++++++++++++++
 tb/tb_regfile_scoreboard.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared core stage, register mux and read-only register constants
// Purpose: types and constants shared by the per-thread register file and its scoreboard.
// Ports: none (package).
package gpu_pkg;

    typedef enum logic [2:0] {
        REQUEST = 3'b011,
        UPDATE  = 3'b110
    } core_state_t;

    typedef enum logic [1:0] {
        ARITHMETIC = 2'b00,
        MEMORY     = 2'b01,
        CONSTANT   = 2'b10,
        NONE       = 2'b11
    } reg_mux_t;

    // Read-only registers sit at the top of the file, counted down from NUM_REGS.
    localparam int RO_BLOCK_IDX_OFFSET  = 3;
    localparam int RO_BLOCK_DIM_OFFSET  = 2;
    localparam int RO_THREAD_IDX_OFFSET = 1;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-load bit vector with set/clear and three lookups
// Purpose: tracks which registers await LSU data. Set and clear may target the same
//          register in one cycle; the set wins because it is a newer load.
// Ports:
//   clock, reset              clock, synchronous active-high reset
//   set_valid, set_address    mark a register pending (load issued)
//   clear_valid, clear_address clear a register's pending bit (load returned)
//   rs/rt/rd_address          lookup addresses
//   rs/rt/rd_pending          current pending bit for each lookup (0 if out of range)
//   pending_any               registered OR of the next-state pending vector
module reg_scoreboard #(
    parameter int NUM_REGS  = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 set_valid,
    input  logic [ADDR_BITS-1:0] set_address,
    input  logic                 clear_valid,
    input  logic [ADDR_BITS-1:0] clear_address,
    input  logic [ADDR_BITS-1:0] rs_address,
    input  logic [ADDR_BITS-1:0] rt_address,
    input  logic [ADDR_BITS-1:0] rd_address,
    output logic                 rs_pending,
    output logic                 rt_pending,
    output logic                 rd_pending,
    output logic                 pending_any
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;

    function automatic logic in_range(input logic [ADDR_BITS-1:0] address);
        return int'(address) < NUM_REGS;
    endfunction

    always_comb begin
        pending_next = pending;
        if (clear_valid && in_range(clear_address)) begin
            pending_next[clear_address] = 1'b0;
        end
        // Applied after the clear so a same-cycle new load keeps the register pending.
        if (set_valid && in_range(set_address)) begin
            pending_next[set_address] = 1'b1;
        end
    end

    always_comb begin
        rs_pending = in_range(rs_address) ? pending[rs_address] : 1'b0;
        rt_pending = in_range(rt_address) ? pending[rt_address] : 1'b0;
        rd_pending = in_range(rd_address) ? pending[rd_address] : 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending     <= '0;
            pending_any <= 1'b0;
        end else begin
            pending     <= pending_next;
            pending_any <= |pending_next;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-thread register file with pending-load scoreboard
// Purpose: SIMT per-thread registers. Loads mark rd pending in UPDATE; the LSU writes
//          the data back later on any cycle. REQUEST latches rs/rt (with writeback
//          bypass) and registers a hazard flag if any operand is still pending.
// Ports:
//   clock, reset                  clock, synchronous active-high reset
//   enable                        thread active; gates decoder-driven activity
//   block_id                      current block index, mirrored into %blockIdx
//   core_state                    core stage (REQUEST / UPDATE)
//   decoded_*                     decoder fields: rd/rs/rt, write enable, mux, immediate
//   alu_out                       ALU result
//   lsu_wb_valid/address/data     decoupled load writeback
//   rs, rt                        latched operand values
//   hazard                        last REQUEST touched a pending register
//   pending_any                   any register pending
module regfile_scoreboard
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8,
    parameter int NUM_REGS          = 16,
    parameter int ADDR_BITS         = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           block_id,
    input  logic [2:0]           core_state,
    input  logic [ADDR_BITS-1:0] decoded_rd_address,
    input  logic [ADDR_BITS-1:0] decoded_rs_address,
    input  logic [ADDR_BITS-1:0] decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0] decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic                 lsu_wb_valid,
    input  logic [ADDR_BITS-1:0] lsu_wb_address,
    input  logic [DATA_BITS-1:0] lsu_wb_data,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt,
    output logic                 hazard,
    output logic                 pending_any
);

    localparam int RO_BASE       = NUM_REGS - RO_BLOCK_IDX_OFFSET;
    localparam int RO_BLOCK_DIM  = NUM_REGS - RO_BLOCK_DIM_OFFSET;
    localparam int RO_THREAD_IDX = NUM_REGS - RO_THREAD_IDX_OFFSET;

    logic [DATA_BITS-1:0] regs [NUM_REGS];

    logic                 wb_accept;
    logic                 update_write;
    logic                 load_issue;
    logic                 is_request;
    logic                 hit_rs, hit_rt, hit_rd;
    logic                 rs_pending, rt_pending, rd_pending;
    logic [DATA_BITS-1:0] rs_next, rt_next;

    function automatic logic writable(input logic [ADDR_BITS-1:0] address);
        return int'(address) < RO_BASE;
    endfunction

    function automatic logic in_range(input logic [ADDR_BITS-1:0] address);
        return int'(address) < NUM_REGS;
    endfunction

    always_comb begin
        wb_accept    = lsu_wb_valid && writable(lsu_wb_address);
        update_write = enable && (core_state == UPDATE) && decoded_reg_write_enable
                       && writable(decoded_rd_address);
        load_issue   = update_write && (decoded_reg_input_mux == MEMORY);
        is_request   = enable && (core_state == REQUEST);

        // A bypass hit only exists for writebacks that are actually accepted.
        hit_rs = wb_accept && (lsu_wb_address == decoded_rs_address);
        hit_rt = wb_accept && (lsu_wb_address == decoded_rt_address);
        hit_rd = wb_accept && (lsu_wb_address == decoded_rd_address);

        rs_next = '0;
        rt_next = '0;
        if (hit_rs) begin
            rs_next = lsu_wb_data;
        end else if (in_range(decoded_rs_address)) begin
            rs_next = regs[decoded_rs_address];
        end
        if (hit_rt) begin
            rt_next = lsu_wb_data;
        end else if (in_range(decoded_rt_address)) begin
            rt_next = regs[decoded_rt_address];
        end
    end

    reg_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_BITS (ADDR_BITS)
    ) u_scoreboard (
        .clock         (clock),
        .reset         (reset),
        .set_valid     (load_issue),
        .set_address   (decoded_rd_address),
        .clear_valid   (wb_accept),
        .clear_address (lsu_wb_address),
        .rs_address    (decoded_rs_address),
        .rt_address    (decoded_rt_address),
        .rd_address    (decoded_rd_address),
        .rs_pending    (rs_pending),
        .rt_pending    (rt_pending),
        .rd_pending    (rd_pending),
        .pending_any   (pending_any)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RO_BASE; i++) begin
                regs[i] <= '0;
            end
            regs[RO_BASE]       <= '0;
            regs[RO_BLOCK_DIM]  <= DATA_BITS'(THREADS_PER_BLOCK);
            regs[RO_THREAD_IDX] <= DATA_BITS'(THREAD_ID);
            rs                  <= '0;
            rt                  <= '0;
            hazard              <= 1'b0;
        end else begin
            if (enable) begin
                regs[RO_BASE] <= DATA_BITS'(block_id);
            end
            if (wb_accept) begin
                regs[lsu_wb_address] <= lsu_wb_data;
            end
            // Issued after the writeback so ALU/constant data wins a same-address race.
            if (update_write) begin
                case (reg_mux_t'(decoded_reg_input_mux))
                    ARITHMETIC: regs[decoded_rd_address] <= alu_out;
                    CONSTANT:   regs[decoded_rd_address] <= decoded_immediate;
                    default:    ;
                endcase
            end
            if (is_request) begin
                rs     <= rs_next;
                rt     <= rt_next;
                hazard <= (rs_pending & ~hit_rs) | (rt_pending & ~hit_rt)
                          | (rd_pending & ~hit_rd);
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] block_id;
    logic [2:0] core_state;
    logic [3:0] decoded_rd_address;
    logic [3:0] decoded_rs_address;
    logic [3:0] decoded_rt_address;
    logic       decoded_reg_write_enable;
    logic [1:0] decoded_reg_input_mux;
    logic [7:0] decoded_immediate;
    logic [7:0] alu_out;
    logic       lsu_wb_valid;
    logic [3:0] lsu_wb_address;
    logic [7:0] lsu_wb_data;
    logic [7:0] rs;
    logic [7:0] rt;
    logic       hazard;
    logic       pending_any;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_REQUEST = 3'b011;
    localparam logic [2:0] ST_UPDATE  = 3'b110;
    localparam logic [1:0] MX_ALU     = 2'b00;
    localparam logic [1:0] MX_MEM     = 2'b01;
    localparam logic [1:0] MX_CONST   = 2'b10;

    regfile_scoreboard #(
        .THREADS_PER_BLOCK (4),
        .THREAD_ID         (2),
        .DATA_BITS         (8),
        .NUM_REGS          (16),
        .ADDR_BITS         (4)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .enable                   (enable),
        .block_id                 (block_id),
        .core_state               (core_state),
        .decoded_rd_address       (decoded_rd_address),
        .decoded_rs_address       (decoded_rs_address),
        .decoded_rt_address       (decoded_rt_address),
        .decoded_reg_write_enable (decoded_reg_write_enable),
        .decoded_reg_input_mux    (decoded_reg_input_mux),
        .decoded_immediate        (decoded_immediate),
        .alu_out                  (alu_out),
        .lsu_wb_valid             (lsu_wb_valid),
        .lsu_wb_address           (lsu_wb_address),
        .lsu_wb_data              (lsu_wb_data),
        .rs                       (rs),
        .rt                       (rt),
        .hazard                   (hazard),
        .pending_any              (pending_any)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        core_state               = ST_IDLE;
        decoded_rd_address       = 4'd0;
        decoded_rs_address       = 4'd0;
        decoded_rt_address       = 4'd0;
        decoded_reg_write_enable = 1'b0;
        decoded_reg_input_mux    = 2'b11;
        decoded_immediate        = 8'h00;
        alu_out                  = 8'h00;
        lsu_wb_valid             = 1'b0;
        lsu_wb_address           = 4'd0;
        lsu_wb_data              = 8'h00;
    endtask

    task automatic request(input logic [3:0] s, input logic [3:0] t, input logic [3:0] d);
        idle();
        core_state         = ST_REQUEST;
        decoded_rs_address = s;
        decoded_rt_address = t;
        decoded_rd_address = d;
    endtask

    task automatic update(input logic [1:0] mux, input logic [3:0] d, input logic [7:0] value);
        idle();
        core_state               = ST_UPDATE;
        decoded_reg_write_enable = 1'b1;
        decoded_reg_input_mux    = mux;
        decoded_rd_address       = d;
        decoded_immediate        = value;
        alu_out                  = value;
    endtask

    task automatic writeback(input logic [3:0] a, input logic [7:0] data);
        lsu_wb_valid   = 1'b1;
        lsu_wb_address = a;
        lsu_wb_data    = data;
    endtask

    initial begin
        idle();
        reset    = 1'b1;
        enable   = 1'b1;
        block_id = 8'h07;
        // Writeback during reset must be ignored by the scoreboard.
        writeback(4'd1, 8'hC3);
        step();
        step();
        check("reset_rs", rs, 8'h00);
        check("reset_rt", rt, 8'h00);
        check("reset_hazard", hazard, 1'b0);
        check("reset_pending_any", pending_any, 1'b0);
        reset = 1'b0;
        idle();

        // 1: read-only registers after reset
        request(4'd15, 4'd14, 4'd0);
        step();
        check("t1_thread_idx", rs, 8'd2);
        check("t1_block_dim", rt, 8'd4);
        check("t1_hazard", hazard, 1'b0);

        // 2: constant write, then ignored write to %blockIdx
        update(MX_CONST, 4'd3, 8'h5A);
        step();
        request(4'd3, 4'd1, 4'd0);
        step();
        check("t2_const_rd3", rs, 8'h5A);
        check("t2_reg1_zero", rt, 8'h00);
        update(MX_CONST, 4'd13, 8'h5A);
        step();
        request(4'd13, 4'd0, 4'd0);
        step();
        check("t2_block_idx", rs, 8'h07);

        // 3: deferred load, hazard, later writeback
        update(MX_MEM, 4'd5, 8'h00);
        step();
        check("t3_pending_any_set", pending_any, 1'b1);
        request(4'd5, 4'd0, 4'd0);
        step();
        check("t3_hazard_set", hazard, 1'b1);
        idle();
        step();
        writeback(4'd5, 8'h77);
        step();
        check("t3_pending_any_clear", pending_any, 1'b0);
        request(4'd5, 4'd0, 4'd0);
        step();
        check("t3_rs_loaded", rs, 8'h77);
        check("t3_hazard_clear", hazard, 1'b0);

        // 4: bypass of same-cycle writeback into REQUEST
        update(MX_MEM, 4'd5, 8'h00);
        step();
        check("t4_pending_any", pending_any, 1'b1);
        request(4'd5, 4'd0, 4'd0);
        writeback(4'd5, 8'h33);
        step();
        check("t4_bypass_rs", rs, 8'h33);
        check("t4_bypass_hazard", hazard, 1'b0);
        check("t4_pending_any_clear", pending_any, 1'b0);

        // 5: new load and writeback on the same register; new load stays pending
        update(MX_MEM, 4'd6, 8'h00);
        writeback(4'd6, 8'h11);
        step();
        check("t5_pending_any", pending_any, 1'b1);
        request(4'd0, 4'd6, 4'd0);
        step();
        check("t5_rt_data", rt, 8'h11);
        check("t5_hazard", hazard, 1'b1);
        // Constant write beats a same-cycle writeback
        update(MX_CONST, 4'd7, 8'h44);
        writeback(4'd7, 8'h55);
        step();
        request(4'd7, 4'd6, 4'd0);
        step();
        check("t5_const_wins", rs, 8'h44);
        check("t5_hazard_still", hazard, 1'b1);

        // 6: enable=0 blocks decoder activity but not writebacks
        enable = 1'b0;
        update(MX_ALU, 4'd2, 8'hEE);
        writeback(4'd4, 8'h99);
        step();
        request(4'd4, 4'd4, 4'd0);
        step();
        check("t6_rs_hold", rs, 8'h44);
        check("t6_hazard_hold", hazard, 1'b1);
        enable = 1'b1;
        request(4'd2, 4'd4, 4'd0);
        step();
        check("t6_reg2_unchanged", rs, 8'h00);
        check("t6_reg4_wb", rt, 8'h99);
        check("t6_hazard_unrelated", hazard, 1'b0);
        // Writeback to a read-only register is ignored
        idle();
        writeback(4'd14, 8'hAA);
        step();
        request(4'd8, 4'd14, 4'd0);
        step();
        check("t6_ro_wb_ignored", rt, 8'd4);
        // rd term alone raises hazard
        update(MX_MEM, 4'd8, 8'h00);
        step();
        request(4'd0, 4'd0, 4'd8);
        step();
        check("t6_hazard_rd", hazard, 1'b1);
        check("t6_pending_any_mid", pending_any, 1'b1);
        // Reset mid-load
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_reset_pending_any", pending_any, 1'b0);
        check("t6_reset_hazard", hazard, 1'b0);
        request(4'd3, 4'd15, 4'd6);
        step();
        check("t6_reset_reg3", rs, 8'h00);
        check("t6_reset_thread_idx", rt, 8'd2);
        check("t6_reset_no_hazard", hazard, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
